aes_cipher_core: RTL and testbench

Iterative AES block cipher core. It computes one full round per clock and supports encryption and decryption (FIPS-197 inverse cipher) for 128/192/256-bit keys, with the number of rounds selected by parameter. It sits after the key-expansion block: it consumes a precomputed round-key schedule and exchanges blocks with its neighbours over valid/ready handshakes, instead of the one-shot trigger/done used by the encrypt-only core.

---
 rtl/aes_cipher_core.sv | 210 +++++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// aes_cipher_core
//   Iterative AES block cipher. One full round is computed per clock, for
//   encryption and for the FIPS-197 inverse cipher, with NR = 10/12/14 rounds
//   (AES-128/192/256). The round-key schedule comes precomputed on w. Blocks
//   enter and leave over valid/ready handshakes.
//
// Parameters
//   NR          number of rounds (10, 12 or 14)
//   DECRYPT_EN  1 builds the inverse datapath; 0 forces every block to encrypt
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   w                   round keys, key k at w[128*k +: 128]
//   in_valid/in_ready   input handshake; in_mode 0 = encrypt, 1 = decrypt
//   in_data             input block, bits [127:120] are byte 0
//   out_valid/out_ready output handshake; out_data result, out_mode echoed mode
//   busy                high while a block is in flight or waiting to leave
module aes_cipher_core #(
  parameter int NR         = 10,
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [128*(NR+1)-1:0] w,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [127:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  out_mode,
  output logic                  busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_cipher_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  // ---------------- GF(2^8) arithmetic and round transforms ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse computed as a^254 by square-and-multiply; 0 maps to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box as inverse followed by the affine map, so no 256-entry tables are kept.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      o[8*n +: 8] = inv ? inv_sbox(s[8*n +: 8]) : sbox(s[8*n +: 8]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4, bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        src = inv ? (col + 4 - row) % 4 : (col + row) % 4;
        o[127-8*(row+4*col) -: 8] = s[127-8*(row+4*src) -: 8];
      end
    end
    return o;
  endfunction

  // Both matrices are circulant, so one coefficient row describes each.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(coef[k], s[127-8*(4*col+(row+k)%4) -: 8]);
        o[127-8*(4*col+row) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // ---------------- control ----------------
  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  state_t       state_q, state_d;
  logic [3:0]   round_q;
  logic         mode_q, mode_in, accept, last_round;
  logic [127:0] data_q, rk_sel, enc_out, dec_out, round_out, enc_sr;
  logic [127:0] rk [0:NR];

  for (genvar k = 0; k <= NR; k++) begin : g_rk
    assign rk[k] = w[128*k +: 128];
  end

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign last_round = (round_q == NR_L);
  // Encrypt walks keys upward from 1, decrypt walks downward from NR-1.
  assign rk_sel     = mode_q ? rk[NR_L - round_q] : rk[round_q];

  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = ROUND;
      ROUND:   if (last_round) state_d = OUT;
      OUT:     if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use <= so every register samples pre-edge values together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_q   <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      case (state_q)
        IDLE: if (accept) begin
          mode_q  <= mode_in;
          round_q <= 4'd1;
        end
        ROUND: if (last_round) begin
          out_data  <= round_out;
          out_mode  <= mode_q;
          out_valid <= 1'b1;
        end else begin
          round_q <= round_q + 4'd1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- datapath ----------------
  assign enc_sr  = shift_rows(sub_bytes(data_q, 1'b0), 1'b0);
  assign enc_out = (last_round ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk_sel;

  if (DECRYPT_EN) begin : g_dec
    logic [127:0] ark;
    assign ark     = sub_bytes(shift_rows(data_q, 1'b1), 1'b1) ^ rk_sel;
    assign dec_out = last_round ? ark : mix_columns(ark, 1'b1);
    assign mode_in = in_mode;
  end else begin : g_no_dec
    assign dec_out = '0;
    assign mode_in = 1'b0;
  end

  assign round_out = mode_q ? dec_out : enc_out;

  // NOTE: the block register has no reset; it is always loaded on accept before it is read.
  always_ff @(posedge clk) begin
    if (accept)                  data_q <= in_data ^ (mode_in ? rk[NR] : rk[0]);
    else if (state_q == ROUND)   data_q <= round_out;
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Testbench for aes_cipher_core. Three instances (NR = 10, 12, 14) share one
// key-schedule bus; a byte-matrix AES model with table S-boxes and its own key
// expansion supplies expected values for random traffic, FIPS-197 vectors
// anchor the known-answer cases.
module tb_aes_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [128*15-1:0]    w_all;
  logic [2:0]           in_valid_v;
  logic                 in_mode, out_ready;
  logic [127:0]         in_data;
  logic                 in_ready_v  [3];
  logic                 out_valid_v [3];
  logic                 out_mode_v  [3];
  logic                 busy_v      [3];
  logic [127:0]         out_data_v  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NRG = 10 + 2*g;
    aes_cipher_core #(.NR(NRG), .DECRYPT_EN(1'b1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .w         (w_all[128*(NRG+1)-1:0]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_data  (out_data_v[g]),
      .out_mode  (out_mode_v[g]),
      .busy      (busy_v[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [7:0]   st [4][4];
  logic [31:0]  ws [60];
  logic [127:0] rks [15];
  logic [7:0]   mfwd [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                                '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
  logic [7:0]   minv [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    while (b != 0) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk = 4/6/8 words.
  task automatic load_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon  = 8'h01;
    w_all = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) ws[i] = key[255-32*i -: 32];
      else begin
        t = ws[i-1];
        if (i % nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        ws[i] = ws[i-nk] ^ t;
      end
    end
    for (int k = 0; k <= nr; k++) begin
      rks[k] = {ws[4*k], ws[4*k+1], ws[4*k+2], ws[4*k+3]};
      w_all[128*k +: 128] = rks[k];
    end
  endtask

  function automatic void add_rk(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = st[r][c] ^ rks[k][127-8*(r+4*c) -: 8];
  endfunction

  function automatic void sub_st(input logic inv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = inv ? inv_sbox[st[r][c]] : sbox[st[r][c]];
  endfunction

  function automatic void shift_st(input logic inv);
    logic [7:0] row [4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c] = st[r][inv ? (c + 4 - r) % 4 : (c + r) % 4];
      for (int c = 0; c < 4; c++) st[r][c] = row[c];
    end
  endfunction

  function automatic void mix_st(input logic inv);
    logic [7:0] a [4];
    logic [7:0] acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = st[r][c];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(inv ? minv[r][k] : mfwd[r][k], a[k]);
        st[r][c] = acc;
      end
    end
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input int nr, input logic dec);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = blk[127-8*(r+4*c) -: 8];
    if (!dec) begin
      add_rk(0);
      for (int rd = 1; rd < nr; rd++) begin
        sub_st(1'b0); shift_st(1'b0); mix_st(1'b0); add_rk(rd);
      end
      sub_st(1'b0); shift_st(1'b0); add_rk(nr);
    end else begin
      add_rk(nr);
      for (int rd = nr - 1; rd >= 1; rd--) begin
        shift_st(1'b1); sub_st(1'b1); add_rk(rd); mix_st(1'b1);
      end
      shift_st(1'b1); sub_st(1'b1); add_rk(0);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = st[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- handshake tasks (called just after a negedge) ----------------
  task automatic send(input int i, input logic [127:0] data, input logic mode, output int t_acc);
    int n;
    n = 0;
    in_data = data;
    in_mode = mode;
    in_valid_v[i] = 1'b1;
    while (!in_ready_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 128'(in_ready_v[i]), 128'(1));
    @(negedge clk);
    t_acc = cyc;
    in_valid_v[i] = 1'b0;
  endtask

  task automatic recv(input int i, output logic [127:0] data, output logic mode, output int t_out);
    int n;
    n = 0;
    while (!out_valid_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 128'(out_valid_v[i]), 128'(1));
    check("busy_with_result", 128'(busy_v[i]), 128'(1));
    data  = out_data_v[i];
    mode  = out_mode_v[i];
    t_out = cyc;
  endtask

  task automatic run_block(input int i, input logic [127:0] data, input logic mode,
                           input logic [127:0] exp, input string tag);
    int           t_acc, t_out;
    logic [127:0] got;
    logic         gm;
    send(i, data, mode, t_acc);
    recv(i, got, gm, t_out);
    check({tag, "_data"}, got, exp);
    check({tag, "_mode"}, 128'(gm), 128'(mode));
    check({tag, "_latency"}, 128'(t_out - t_acc), 128'(10 + 2*i));
    @(negedge clk);
    check({tag, "_after_hs"}, 128'({out_valid_v[i], in_ready_v[i], busy_v[i]}), 128'(3'b010));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] blk [4];
  logic [127:0] expv [4];
  logic [127:0] gotv [4];
  logic         gmv [4];
  int           tv [4];
  logic [127:0] got;
  logic [255:0] rkey;
  logic         gm, saw, rmode;
  int           t_acc, t_out, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    reset = 1'b1;
    in_valid_v = '0;
    in_mode = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    w_all = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int g = 0; g < 3; g++) begin
      check("reset_ctrl", 128'({out_valid_v[g], busy_v[g], in_ready_v[g], out_mode_v[g]}), 128'(4'b0010));
      check("reset_data", out_data_v[g], '0);
    end

    // FIPS-197 known answers
    load_key(K128, 4, 10);
    run_block(0, PT, 1'b0, CT128, "fips128_enc");
    run_block(0, CT128, 1'b1, PT, "fips128_dec");
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    run_block(0, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1,
              128'h3243f6a8885a308d313198a2e0370734, "fips_b_dec");
    load_key(K192, 6, 12);
    run_block(1, PT, 1'b0, CT192, "fips192_enc");
    run_block(1, CT192, 1'b1, PT, "fips192_dec");
    load_key(K256, 8, 14);
    run_block(2, PT, 1'b0, CT256, "fips256_enc");
    run_block(2, CT256, 1'b1, PT, "fips256_dec");

    // random keys, blocks and modes against the model
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        rkey = {rand128(), rand128()};
        load_key(rkey, 4 + 2*g, 10 + 2*g);
        blk[0] = rand128();
        rmode = 1'($urandom_range(0, 1));
        run_block(g, blk[0], rmode, aes_ref(blk[0], 10 + 2*g, rmode), "rand");
      end
    end

    // backpressure: result held, new input ignored
    load_key(K128, 4, 10);
    out_ready = 1'b0;
    send(0, PT, 1'b0, t_acc);
    recv(0, got, gm, t_out);
    check("bp_data", got, CT128);
    for (int k = 0; k < 20; k++) begin
      in_data = rand128();
      in_mode = 1'($urandom_range(0, 1));
      in_valid_v[0] = 1'b1;
      @(negedge clk);
      check("bp_hold_data", out_data_v[0], CT128);
      check("bp_hold_ctrl", 128'({out_valid_v[0], in_ready_v[0], out_mode_v[0]}), 128'(3'b100));
    end
    in_valid_v[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 128'({out_valid_v[0], in_ready_v[0], busy_v[0]}), 128'(3'b010));

    // back-to-back with in_valid held high, alternating modes
    rkey = {rand128(), rand128()};
    load_key(rkey, 4, 10);
    for (int k = 0; k < 4; k++) begin
      blk[k]  = rand128();
      expv[k] = aes_ref(blk[k], 10, k % 2 == 1);
    end
    fork
      begin
        in_valid_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          in_data = blk[k];
          in_mode = (k % 2 == 1);
          n = 0;
          while (!in_ready_v[0] && n < 100) begin
            @(negedge clk);
            n++;
          end
          check("b2b_accept", 128'(in_ready_v[0]), 128'(1));
          @(negedge clk);
        end
        in_valid_v[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          recv(0, gotv[k], gmv[k], tv[k]);
          @(negedge clk);
        end
      end
    join
    for (int k = 0; k < 4; k++) begin
      check("b2b_data", gotv[k], expv[k]);
      check("b2b_mode", 128'(gmv[k]), 128'(k % 2));
      if (k > 0) check("b2b_spacing", 128'(tv[k] - tv[k-1]), 128'(12));
    end

    // reset while round 5 is being computed
    load_key(K128, 4, 10);
    send(0, PT, 1'b0, t_acc);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ctrl", 128'({out_valid_v[0], busy_v[0], in_ready_v[0], out_mode_v[0]}), 128'(4'b0010));
    check("rst_mid_data", out_data_v[0], '0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_v[0]) saw = 1'b1;
    end
    check("rst_mid_no_stale", 128'(saw), 128'(0));
    run_block(0, PT, 1'b0, CT128, "rst_mid_next");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
